// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module mult_div_unit #(
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [dataWidth-1:0] SrcA,
  input  logic [dataWidth-1:0] SrcB,
  input  logic                 mthi,
  input  logic                 mtlo,
  input  logic [dataWidth-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [dataWidth-1:0] HI,
  output logic [dataWidth-1:0] LO
);

  localparam int CW = (dataWidth > 1) ? $clog2(dataWidth) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          count;
  logic [dataWidth-1:0]   acc, qreg, mreg;
  logic                   op_div, neg_a, neg_q, dz;

  logic                   accept, last, sgn_a, sgn_b, ge;
  logic [dataWidth:0]     shifted, sum;
  logic [dataWidth-1:0]   acc_step, q_step, quo, rem, hi_res, lo_res;
  logic [2*dataWidth-1:0] prod, prod_fix;

  assign accept      = start && (state != RUN);
  assign last        = (count == CW'(dataWidth - 1));
  // op[0] selects the unsigned variants, so signs only matter when it is low
  assign sgn_a       = !op[0] && SrcA[dataWidth-1];
  assign sgn_b       = !op[0] && SrcB[dataWidth-1];
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign div_by_zero = done && dz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc is the product high half / partial remainder; qreg is multiplier / dividend-then-quotient
  always_comb begin
    shifted = {acc, qreg[dataWidth-1]};
    ge      = (shifted >= {1'b0, mreg});
    sum     = {1'b0, acc} + (qreg[0] ? {1'b0, mreg} : '0);
    if (op_div) begin
      // remainder always fits in dataWidth bits, so modular subtraction is exact
      acc_step = ge ? (shifted[dataWidth-1:0] - mreg) : shifted[dataWidth-1:0];
      q_step   = {qreg[dataWidth-2:0], ge};
    end else begin
      acc_step = sum[dataWidth:1];
      q_step   = {sum[0], qreg[dataWidth-1:1]};
    end
    prod     = {acc_step, q_step};
    prod_fix = neg_q ? -prod : prod;
    quo      = dz ? '1 : (neg_q ? -q_step : q_step);
    rem      = neg_a ? -acc_step : acc_step;
    hi_res   = op_div ? rem : prod_fix[2*dataWidth-1:dataWidth];
    lo_res   = op_div ? quo : prod_fix[dataWidth-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      qreg   <= '0;
      mreg   <= '0;
      op_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_q  <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      count  <= '0;
      acc    <= '0;
      qreg   <= sgn_a ? -SrcA : SrcA;
      mreg   <= sgn_b ? -SrcB : SrcB;
      op_div <= op[1];
      neg_a  <= sgn_a;
      neg_q  <= sgn_a ^ sgn_b;
      dz     <= op[1] && (SrcB == '0);
    end else if (state == RUN) begin
      count  <= count + 1'b1;
      acc    <= acc_step;
      qreg   <= q_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (state == RUN) begin
      if (last) begin
        HI <= hi_res;
        LO <= lo_res;
      end
    end else if (!start) begin
      if (mthi) HI <= wdata;
      if (mtlo) LO <= wdata;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] SrcA = '0, SrcB = '0, wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] HI, LO;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.dataWidth(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  exp_t e_mon;
  always begin
    @(posedge clk);
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 required no pending result");
      end else begin
        e_mon = sb.pop_front();
        chk("result_hi", HI, e_mon.hi);
        chk("result_lo", LO, e_mon.lo);
        chk("div_by_zero", div_by_zero, e_mon.dz);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.dz = edz;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
    @(negedge clk);
    op = o; SrcA = a; SrcB = b; start = 1'b1;
    push_exp(ehi, elo, edz);
    @(posedge clk);
    #1;
    chk("busy_after_start", busy, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // the start edge counts as edge 1
  task automatic wait_done(input int first_n, input int exp_lat);
    int n;
    n = first_n;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_latency", n, exp_lat);
  endtask

  task automatic run_vec(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                         input int gap);
    repeat (gap) @(posedge clk);
    issue(o, a, b, ehi, elo, edz);
    wait_done(1, W + 1);
  endtask

  logic [W-1:0] hold_hi, hold_lo;
  int           n_done;

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", div_by_zero, 0);
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mtlo = 1'b0; wdata = 32'hCAFE_0001;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", HI, 32'hCAFE_0001);
    chk("mtlo_lo", LO, 32'h1234_5678);

    run_vec(OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1);
    run_vec(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_vec(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 2);
    run_vec(OP_DIVU,  32'd100,       32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0);
    run_vec(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 2);
    run_vec(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
    run_vec(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 2);
    run_vec(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 0);
    run_vec(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2);
    run_vec(OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0, 0);

    // start and mthi/mtlo in the same IDLE cycle: start wins
    repeat (2) @(posedge clk);
    hold_hi = HI;
    hold_lo = LO;
    @(negedge clk);
    op = OP_MULTU; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    push_exp(32'h0, 32'd15, 1'b0);
    @(posedge clk);
    #1;
    chk("start_wins_hi", HI, hold_hi);
    chk("start_wins_lo", LO, hold_lo);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wait_done(1, W + 1);

    // start plus mthi at RUN step 5 must be ignored
    repeat (2) @(posedge clk);
    issue(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);
    repeat (4) @(negedge clk);
    hold_hi = HI;
    op = OP_MULT; SrcA = 32'd3; SrcB = 32'd4; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("run_busy_kept", busy, 1);
    chk("run_mthi_ignored", HI, hold_hi);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(6, W + 1);
    @(posedge clk);
    #1;
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_done", done, 0);

    // reset at RUN step 10 aborts the operation
    issue(OP_MULTU, 32'h0000_1234, 32'h0000_0010, 32'h0, 32'h0001_2340, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_hi_held", HI, 0);
    chk("abort_lo_held", LO, 0);

    run_vec(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
